// File: rtl/gcd_pkg.sv
// Shared GCD definitions: sequencer state encoding and default sizing
// for the GCD engine and the sequencer that feeds it.
package gcd_pkg;

  localparam int GCD_WIDTH_DEFAULT   = 8;
  localparam int GCD_TIMEOUT_DEFAULT = 255;
  localparam int GCD_CNT_W           = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_RESP
  } gcd_seq_state_e;

endpackage

// File: rtl/gcd_timeout_counter.sv
// Saturating RUN-cycle counter; terminal_o flags the last cycle a job may
// run before it is abandoned.
module gcd_timeout_counter
  import gcd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = GCD_TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic terminal_o
);

  localparam logic [GCD_CNT_W-1:0] LAST_CNT = GCD_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [GCD_CNT_W-1:0] count_q;
  logic [GCD_CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal_o = (count_q == LAST_CNT);

endmodule

// File: rtl/gcd_sequencer.sv
// Request/response wrapper around an iterative GCD engine: latches operands,
// short-circuits zero operands, enforces a RUN timeout and holds the result.
module gcd_sequencer
  import gcd_pkg::*;
#(
  parameter int WIDTH          = GCD_WIDTH_DEFAULT,
  parameter int TIMEOUT_CYCLES = GCD_TIMEOUT_DEFAULT
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  output logic [WIDTH-1:0] gcd_operand_a_o,
  output logic [WIDTH-1:0] gcd_operand_b_o,
  output logic             gcd_enable_o,
  input  logic [WIDTH-1:0] gcd_i,
  input  logic             gcd_done_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_gcd_o,
  output logic             rsp_timeout_o,
  output logic             busy_o
);

  gcd_seq_state_e   state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] rsp_gcd_q, rsp_gcd_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic             cnt_terminal;

  gcd_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (state_q != ST_RUN),
    .enable_i  (state_q == ST_RUN),
    .terminal_o(cnt_terminal)
  );

  always_comb begin
    state_d       = state_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    rsp_gcd_d     = rsp_gcd_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          op_a_d = req_a_i;
          op_b_d = req_b_i;
          // With one operand zero the OR is the other operand; both zero gives 0.
          if ((req_a_i == '0) || (req_b_i == '0)) begin
            rsp_gcd_d     = req_a_i | req_b_i;
            rsp_timeout_d = 1'b0;
            state_d       = ST_RESP;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: state_d = ST_RUN;
      ST_RUN: begin
        if (gcd_done_i) begin
          rsp_gcd_d     = gcd_i;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RESP;
        end else if (cnt_terminal) begin
          rsp_gcd_d     = '0;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      op_a_q        <= '0;
      op_b_q        <= '0;
      rsp_gcd_q     <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      rsp_gcd_q     <= rsp_gcd_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign req_ready_o     = (state_q == ST_IDLE) && !reset_i;
  assign gcd_enable_o    = (state_q == ST_RUN);
  assign rsp_valid_o     = (state_q == ST_RESP);
  assign busy_o          = (state_q != ST_IDLE);
  assign gcd_operand_a_o = op_a_q;
  assign gcd_operand_b_o = op_b_q;
  assign rsp_gcd_o       = rsp_gcd_q;
  assign rsp_timeout_o   = rsp_timeout_q;

endmodule

// File: tb/tb_gcd_sequencer.sv
// Self-checking bench for gcd_sequencer with a behavioural GCD engine whose
// done latency is chosen per job.
module tb_gcd_sequencer;

  localparam int W = 8;
  localparam int T = 10;

  logic         clk;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         gcd_enable;
  logic [W-1:0] gcd_in;
  logic         gcd_done;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_gcd;
  logic         rsp_timeout;
  logic         busy;

  int checks = 0;
  int errors = 0;

  gcd_sequencer #(
    .WIDTH(W),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_a_i        (req_a),
    .req_b_i        (req_b),
    .gcd_operand_a_o(op_a),
    .gcd_operand_b_o(op_b),
    .gcd_enable_o   (gcd_enable),
    .gcd_i          (gcd_in),
    .gcd_done_i     (gcd_done),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_gcd_o      (rsp_gcd),
    .rsp_timeout_o  (rsp_timeout),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine model: raises done on the done_at-th consecutive enable cycle (0 = never).
  int           done_at  = 0;
  int           run_cnt  = 0;
  logic         spurious = 1'b0;
  logic [W-1:0] gcd_val  = '0;

  always @(posedge clk) run_cnt <= gcd_enable ? run_cnt + 1 : 0;
  assign gcd_done = spurious | (gcd_enable && (done_at != 0) && (run_cnt == done_at - 1));
  assign gcd_in   = spurious ? 8'hA5 : gcd_val;

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    int x, y, t;
    x = int'(a);
    y = int'(b);
    if (x == 0) return b;
    if (y == 0) return a;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x[W-1:0];
  endfunction

  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input int dat,
                         input int hold, input string name);
    logic         zero, exp_to;
    logic [W-1:0] exp_g;
    int           exp_en, exp_lat, lat, en;
    zero    = (a == 0) || (b == 0);
    exp_to  = !zero && ((dat == 0) || (dat > T));
    exp_g   = exp_to ? '0 : ref_gcd(a, b);
    exp_en  = zero ? 0 : (exp_to ? T : dat);
    exp_lat = zero ? 1 : 2 + exp_en;
    done_at = dat;
    gcd_val = ref_gcd(a, b);

    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s req_ready got %b want 1", name, req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_a = W'($urandom);
    req_b = W'($urandom);
    checks++;
    if (op_a !== a || op_b !== b) begin
      errors++;
      $display("FAIL %s operands got %0d,%0d want %0d,%0d", name, op_a, op_b, a, b);
    end

    lat = 1;
    en  = 0;
    while (rsp_valid !== 1'b1 && lat < 200) begin
      if (gcd_enable === 1'b1) en++;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if (en != exp_en) begin
      errors++;
      $display("FAIL %s enable_cycles got %0d want %0d", name, en, exp_en);
    end
    checks++;
    if (rsp_gcd !== exp_g || rsp_timeout !== exp_to) begin
      errors++;
      $display("FAIL %s result got %0d/to=%b want %0d/to=%b", name, rsp_gcd, rsp_timeout,
               exp_g, exp_to);
    end
    checks++;
    if (gcd_enable !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s resp_ctrl got en=%b rdy=%b busy=%b want 0,0,1", name, gcd_enable,
               req_ready, busy);
    end

    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_a     = W'($urandom);
      req_b     = W'($urandom);
      spurious  = i[0];
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_gcd !== exp_g || rsp_timeout !== exp_to ||
          req_ready !== 1'b0 || op_a !== a || op_b !== b) begin
        errors++;
        $display("FAIL %s hold[%0d] got v=%b g=%0d to=%b rdy=%b want v=1 g=%0d to=%b rdy=0",
                 name, i, rsp_valid, rsp_gcd, rsp_timeout, req_ready, exp_g, exp_to);
      end
    end
    spurious  = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || op_a !== a || op_b !== b) begin
      errors++;
      $display("FAIL %s after_hs got v=%b busy=%b rdy=%b ops=%0d,%0d want 0,0,1 ops=%0d,%0d",
               name, rsp_valid, busy, req_ready, op_a, op_b, a, b);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 1'b1;
    req_a     = 8'd5;
    req_b     = 8'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 || gcd_enable !== 1'b0 ||
        rsp_gcd !== '0 || rsp_timeout !== 1'b0 || op_a !== '0 || op_b !== '0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b busy=%b v=%b en=%b g=%0d to=%b ops=%0d,%0d",
               req_ready, busy, rsp_valid, gcd_enable, rsp_gcd, rsp_timeout, op_a, op_b);
    end
    reset     = 1'b0;
    req_valid = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release req_ready got %b want 1", req_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_spurious_idle();
    spurious = 1'b1;
    repeat (4) @(negedge clk);
    spurious = 1'b0;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_done got busy=%b v=%b want 0,0", busy, rsp_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    done_at   = 0;
    req_a     = 8'd9;
    req_b     = 8'd6;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (gcd_enable !== 1'b1) begin
      errors++;
      $display("FAIL midrun_enable got %b want 1", gcd_enable);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (gcd_enable !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 || op_a !== '0) begin
      errors++;
      $display("FAIL midrun_reset got en=%b busy=%b v=%b opa=%0d want 0,0,0,0", gcd_enable,
               busy, rsp_valid, op_a);
    end
    @(negedge clk);
    reset = 1'b0;
    seen  = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrun_ghost active_cycles got %0d want 0", seen);
    end
    run_job(8'd27, 8'd18, 4, 1, "after_reset");
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int j = 0; j < 40; j++) begin
      a = W'($urandom);
      b = W'($urandom);
      if ($urandom_range(0, 5) == 0) a = '0;
      if ($urandom_range(0, 5) == 0) b = '0;
      run_job(a, b, int'($urandom_range(0, 12)), int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    run_job(8'd48, 8'd18, 5, 0, "basic");
    run_job(8'd0, 8'd35, 3, 0, "zero_a");
    run_job(8'd0, 8'd0, 3, 0, "zero_both");
    run_job(8'd35, 8'd0, 3, 0, "zero_b");
    run_job(8'd20, 8'd15, 1, 0, "first_cycle_done");
    run_job(8'd200, 8'd150, 0, 0, "timeout");
    run_job(8'd200, 8'd150, 10, 0, "done_at_limit");
    run_job(8'd200, 8'd150, 11, 0, "done_too_late");
    run_job(8'd91, 8'd65, 4, 20, "backpressure");
    test_spurious_idle();
    run_job(8'd12, 8'd8, 3, 0, "b2b_1");
    run_job(8'd7, 8'd3, 1, 0, "b2b_2");
    run_job(8'd100, 8'd75, 6, 0, "b2b_3");
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_sequencer.md
GCD_SEQUENCER -- requirements
Module: gcd_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, maximum RUN cycles before a job is abandoned (range 1..2^16-1).
REQ-003 clk_i  input  1  single clock; all logic rising-edge.
REQ-004 reset_i  input  1  synchronous, active-high reset.
REQ-005 req_valid_i  input  1  requester presents an operand pair.
REQ-006 req_ready_o  output  1  sequencer accepts the pair this cycle.
REQ-007 req_a_i  input  WIDTH  operand A.
REQ-008 req_b_i  input  WIDTH  operand B.
REQ-009 gcd_operand_a_o  output  WIDTH  registered operand A to the GCD engine.
REQ-010 gcd_operand_b_o  output  WIDTH  registered operand B to the GCD engine.
REQ-011 gcd_enable_o  output  1  level enable to the GCD engine.
REQ-012 gcd_i  input  WIDTH  engine result.
REQ-013 gcd_done_i  input  1  engine result valid.
REQ-014 rsp_valid_o  output  1  response available.
REQ-015 rsp_ready_i  input  1  consumer takes the response.
REQ-016 rsp_gcd_o  output  WIDTH  result.
REQ-017 rsp_timeout_o  output  1  response is a timeout, rsp_gcd_o = 0.
REQ-018 busy_o  output  1  high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, RUN and RESP, encoded as an enum.
REQ-020 IDLE: req_ready_o = 1. A handshake (req_valid_i & req_ready_o) latches both operands into gcd_operand_a_o/gcd_operand_b_o and moves to LOAD. req_ready_o is 0 in every other state.
REQ-021 Zero fast path, applied on the accept edge: if either operand is 0, the block skips the engine and goes directly to RESP with rsp_gcd_o = the other operand (gcd(0,0) = 0) and rsp_timeout_o = 0.
REQ-022 LOAD: lasts exactly one cycle with gcd_enable_o = 0, so the engine always sees enable low for at least one cycle between jobs. Next state is RUN.
REQ-023 RUN: gcd_enable_o = 1 and the timeout counter increments each cycle, starting from 0 on entry.
REQ-024 In RUN, gcd_done_i = 1 captures gcd_i into rsp_gcd_o, clears rsp_timeout_o, deasserts gcd_enable_o on the next cycle and moves to RESP.
REQ-025 In RUN, if the counter reaches TIMEOUT_CYCLES-1 with gcd_done_i = 0, the block sets rsp_timeout_o = 1 and rsp_gcd_o = 0 and moves to RESP.
REQ-026 If gcd_done_i and the timeout condition occur in the same cycle, done wins: the result is captured and rsp_timeout_o = 0.
REQ-027 gcd_done_i outside RUN SHALL be ignored.
REQ-028 RESP: rsp_valid_o = 1, with rsp_gcd_o and rsp_timeout_o held stable until rsp_valid_o & rsp_ready_i, then the FSM returns to IDLE.
REQ-029 rsp_valid_o SHALL NOT depend combinationally on rsp_ready_i.
REQ-030 A new request is accepted no earlier than the cycle after the response handshake.
REQ-031 Minimum job latency, accept to rsp_valid_o: 1 cycle on the zero fast path; 3 cycles when the engine asserts done on its first RUN cycle.
REQ-032 The timeout counter width SHALL be 16 bits and SHALL saturate rather than wrap.
REQ-033 Operand outputs are held constant from accept until the FSM next leaves IDLE.

Reset
REQ-034 While reset_i = 1 at a clock edge: state = IDLE, gcd_enable_o = 0, rsp_valid_o = 0, rsp_timeout_o = 0, rsp_gcd_o = 0, operand outputs = 0, counter = 0, busy_o = 0, and req_ready_o is held at 0.
REQ-035 Reset in any state, including mid-RUN, SHALL drop gcd_enable_o on the same edge and discard the job without producing a response.

Structure
REQ-036 The FSM state enum and the default WIDTH and TIMEOUT_CYCLES constants SHALL live in shared package gcd_pkg, alongside the existing GCD definitions.
REQ-037 The timeout counter SHALL be a sub-module gcd_timeout_counter (ports: clear, enable, terminal-count output); all other logic is flat.

Verification
REQ-038 Basic job: A=48, B=18, model engine asserts done with 6 after 5 RUN cycles, rsp_ready_i = 1 -> rsp_gcd_o = 6, rsp_timeout_o = 0, enable high exactly 5 cycles.
REQ-039 Zero path: A=0, B=35 -> rsp_valid_o 1 cycle after accept, rsp_gcd_o = 35, gcd_enable_o never asserted; A=0, B=0 -> rsp_gcd_o = 0.
REQ-040 Timeout: TIMEOUT_CYCLES = 10, engine never done -> rsp_timeout_o = 1, rsp_gcd_o = 0 after exactly 10 RUN cycles; a done asserted on the 10th RUN cycle -> result returned, rsp_timeout_o = 0.
REQ-041 Backpressure: hold rsp_ready_i = 0 for 20 cycles with req_valid_i = 1 and new operands -> response held stable, req_ready_o = 0 throughout, next job accepted only after the handshake.
REQ-042 Back-to-back: jobs (12,8), (7,3), (100,75) -> responses 4, 1, 25 in order, with at least one enable-low cycle between jobs.
REQ-043 Reset mid-RUN at cycle 3 of a job -> gcd_enable_o = 0 on the reset edge, no response ever appears, and the next job runs normally.
